// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_sequencer                                            |
// | Purpose  : FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit MIPS        |
// |            multi-cycle datapath. MEM_HANDSHAKE_EN enables mem_ready waits  |
// |            with a bounded wait counter and a sticky mem_err flag.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module multicycle_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       sign_or_zero,
    output logic       reg_write,
    output logic       instr_done,
    output logic       mem_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SLI  = 3'b001;
    localparam logic [2:0] c_OP_J    = 3'b010;
    localparam logic [2:0] c_OP_JAL  = 3'b011;
    localparam logic [2:0] c_OP_LW   = 3'b100;
    localparam logic [2:0] c_OP_SW   = 3'b101;
    localparam logic [2:0] c_OP_BEQ  = 3'b110;
    localparam logic [2:0] c_OP_ADDI = 3'b111;

    state_t r_state;
    state_t w_state_next;
    logic   w_ready;
    logic   w_timeout;

`ifdef MEM_HANDSHAKE_EN
    logic [3:0] r_wait;
    logic       r_mem_err;
    logic       w_mem_state;

    assign w_ready     = mem_ready;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM);
    // Abandon the access on the cycle whose missed ready would bring the count to WAIT_MAX
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait == 4'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait    <= 4'd0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            if ((w_state_next != r_state) || w_timeout) begin
                r_wait <= 4'd0;
            end else if (w_mem_state && !mem_ready) begin
                r_wait <= r_wait + 4'd1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    logic w_unused_ready;

    assign w_unused_ready = mem_ready;
    assign w_ready        = 1'b1;
    assign w_timeout      = 1'b0;
    assign mem_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign state = r_state;

    always_comb begin
        w_state_next = r_state;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        alu_op       = 2'b00;
        alu_src      = 1'b0;
        sign_or_zero = 1'b1;
        reg_write    = 1'b0;
        instr_done   = 1'b0;

        // Strobes stay quiet while reset is held so an aborted access never completes
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (w_timeout) begin
                        w_state_next = S_FETCH;
                    end else if (w_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == c_OP_J) begin
                        pc_write     = 1'b1;
                        pc_src       = 2'b10;
                        instr_done   = 1'b1;
                        w_state_next = S_FETCH;
                    end else if (opcode == c_OP_JAL) begin
                        w_state_next = S_WB;
                    end else begin
                        w_state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        c_OP_ADD: begin
                            w_state_next = S_WB;
                        end
                        c_OP_SLI: begin
                            alu_op       = 2'b10;
                            alu_src      = 1'b1;
                            sign_or_zero = 1'b0;
                            w_state_next = S_WB;
                        end
                        c_OP_ADDI: begin
                            alu_op       = 2'b11;
                            alu_src      = 1'b1;
                            w_state_next = S_WB;
                        end
                        c_OP_LW, c_OP_SW: begin
                            alu_op       = 2'b11;
                            alu_src      = 1'b1;
                            w_state_next = S_MEM;
                        end
                        c_OP_BEQ: begin
                            alu_op       = 2'b01;
                            pc_write     = alu_zero;
                            pc_src       = 2'b01;
                            instr_done   = 1'b1;
                            w_state_next = S_FETCH;
                        end
                        default: begin
                            w_state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    i_or_d  = 1'b1;
                    alu_op  = 2'b11;
                    alu_src = 1'b1;
                    if (opcode == c_OP_LW) begin
                        mem_read = 1'b1;
                    end else if (opcode == c_OP_SW) begin
                        mem_write = 1'b1;
                    end
                    if (w_timeout) begin
                        w_state_next = S_FETCH;
                    end else if (w_ready) begin
                        if (opcode == c_OP_LW) begin
                            w_state_next = S_WB;
                        end else begin
                            instr_done   = (opcode == c_OP_SW);
                            w_state_next = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    reg_write    = 1'b1;
                    instr_done   = 1'b1;
                    w_state_next = S_FETCH;
                    case (opcode)
                        c_OP_ADD: begin
                            reg_dst = 2'b01;
                        end
                        c_OP_LW: begin
                            mem_to_reg = 2'b01;
                        end
                        c_OP_JAL: begin
                            reg_dst    = 2'b10;
                            mem_to_reg = 2'b10;
                            pc_write   = 1'b1;
                            pc_src     = 2'b10;
                        end
                        default: begin
                            reg_dst    = 2'b00;
                            mem_to_reg = 2'b00;
                        end
                    endcase
                end
                default: begin
                    w_state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// Randomized self-checking bench for multicycle_sequencer: every cycle's outputs are
// compared against a phase-by-phase model of the instruction rules.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       sign_or_zero;
    logic       reg_write;
    logic       instr_done;
    logic       mem_err;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    bit g_err   = 1'b0;

    localparam int PH_F = 0, PH_D = 1, PH_X = 2, PH_M = 3, PH_W = 4;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SLI = 3'd1, OP_J = 3'd2, OP_JAL = 3'd3,
                           OP_LW = 3'd4, OP_SW = 3'd5, OP_BEQ = 3'd6, OP_ADDI = 3'd7;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       sign_or_zero;
        logic       reg_write;
        logic       instr_done;
        logic       mem_err;
    } outs_t;

    multicycle_sequencer #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .alu_src(alu_src), .sign_or_zero(sign_or_zero), .reg_write(reg_write),
        .instr_done(instr_done), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{state, pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_dst,
              mem_to_reg, alu_op, alu_src, sign_or_zero, reg_write, instr_done, mem_err};
        return o;
    endfunction

    function automatic outs_t rst_outs(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state        = st;
        o.sign_or_zero = 1'b1;
        return o;
    endfunction

    // Expected strobes for one cycle of an instruction in phase ph
    function automatic outs_t model(input int ph, input logic [2:0] op, input bit rdy, input bit z);
        outs_t o;
        o = rst_outs(3'(ph));
        o.mem_err = g_err;
        case (ph)
            PH_F: begin
                o.mem_read = 1'b1;
                o.ir_write = rdy;
                o.pc_write = rdy;
            end
            PH_D: begin
                if (op == OP_J) begin
                    o.pc_write   = 1'b1;
                    o.pc_src     = 2'd2;
                    o.instr_done = 1'b1;
                end
            end
            PH_X: begin
                o.sign_or_zero = (op != OP_SLI);
                o.alu_src      = (op == OP_SLI) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
                o.alu_op       = (op == OP_BEQ) ? 2'd1 : (op == OP_SLI) ? 2'd2 :
                                 (op == OP_ADD) ? 2'd0 : 2'd3;
                if (op == OP_BEQ) begin
                    o.pc_write   = z;
                    o.pc_src     = 2'd1;
                    o.instr_done = 1'b1;
                end
            end
            PH_M: begin
                o.i_or_d     = 1'b1;
                o.alu_op     = 2'd3;
                o.alu_src    = 1'b1;
                o.mem_read   = (op == OP_LW);
                o.mem_write  = (op == OP_SW);
                o.instr_done = (op == OP_SW) && rdy;
            end
            default: begin
                o.reg_write  = 1'b1;
                o.instr_done = 1'b1;
                o.reg_dst    = (op == OP_ADD) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0;
                o.mem_to_reg = (op == OP_LW) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0;
                if (op == OP_JAL) begin
                    o.pc_write = 1'b1;
                    o.pc_src   = 2'd2;
                end
            end
        endcase
        return o;
    endfunction

    task automatic step(input int ph, input logic [2:0] op, input bit drv_rdy, input bit exp_rdy,
                        input string tag);
        bit z;
        @(negedge clk);
        z         = 1'($urandom_range(0, 1));
        reset     = 1'b1;
        opcode    = (ph == PH_F) ? 3'($urandom_range(0, 7)) : op;
        mem_ready = drv_rdy;
        alu_zero  = z;
        #1;
        check(tag, 32'(dut_outs()), 32'(model(ph, op, exp_rdy, z)));
        if (reg_write && mem_write) check("excl_rw_mw", 32'd1, 32'd0);
    endtask

    // One memory phase (FETCH or MEM) with w missed-ready cycles before completion
    task automatic mem_phase(input int ph, input logic [2:0] op, input int w, input string tag);
`ifdef MEM_HANDSHAKE_EN
        for (int k = 0; k < w; k++) step(ph, op, 1'b0, 1'b0, {tag, "_wait"});
        step(ph, op, 1'b1, 1'b1, tag);
`else
        step(ph, op, (w == 0) ? 1'b1 : 1'b0, 1'b1, tag);
`endif
    endtask

    task automatic run_instr(input logic [2:0] op, input int fw, input int mw);
        mem_phase(PH_F, op, fw, "fetch");
        step(PH_D, op, 1'($urandom_range(0, 1)), 1'b1, "decode");
        if (op == OP_J) return;
        if (op == OP_JAL) begin
            step(PH_W, op, 1'($urandom_range(0, 1)), 1'b1, "wb_jal");
            return;
        end
        step(PH_X, op, 1'($urandom_range(0, 1)), 1'b1, "exec");
        if (op == OP_BEQ) return;
        if ((op == OP_LW) || (op == OP_SW)) begin
            mem_phase(PH_M, op, mw, "mem");
            if (op == OP_SW) return;
        end
        step(PH_W, op, 1'($urandom_range(0, 1)), 1'b1, "wb");
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = 3'd0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_state", 32'(dut_outs()), 32'(rst_outs(3'd0)));

        run_instr(OP_ADD, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_BEQ, 1, 0);
        run_instr(OP_JAL, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_SLI, 0, 0);
        run_instr(OP_ADDI, 2, 0);

        // Reset asserted while a store is in MEM
        step(PH_F, OP_SW, 1'b1, 1'b1, "rst_fetch");
        step(PH_D, OP_SW, 1'b1, 1'b1, "rst_decode");
        step(PH_X, OP_SW, 1'b1, 1'b1, "rst_exec");
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_in_mem", 32'(dut_outs()), 32'(rst_outs(3'd3)));
        @(negedge clk);
        #1;
        check("rst_edge1", 32'(dut_outs()), 32'(rst_outs(3'd0)));
        @(negedge clk);
        #1;
        check("rst_edge2", 32'(dut_outs()), 32'(rst_outs(3'd0)));
        run_instr(OP_SW, 0, 0);

        for (int i = 0; i < 150; i++) begin
            run_instr(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef MEM_HANDSHAKE_EN
        // Fetch starved of mem_ready until the wait limit is hit
        for (int k = 0; k < 15; k++) step(PH_F, OP_ADD, 1'b0, 1'b0, "to_wait");
        g_err = 1'b1;
        step(PH_F, OP_ADD, 1'b0, 1'b0, "to_err");
        step(PH_F, OP_ADD, 1'b0, 1'b0, "to_sticky");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        g_err = 1'b0;
        check("to_clear", 32'(dut_outs()), 32'(rst_outs(3'd0)));
        for (int i = 0; i < 20; i++) begin
            run_instr(3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 2));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
